// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: runs one core load/store on a req/gnt/rvalid bus,
// with lane steering, load extension and misalign/illegal/timeout error reporting.
//
// state  | meaning
// IDLE   | ready for a new request
// REQ    | mem_req asserted, waiting for mem_gnt
// WAIT_R | load granted, waiting for mem_rvalid
// DONE   | rsp_valid pulse (error path waits one extra cycle first)
module lsu_bus_ctrl #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             err_wait;
  logic             r_we;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;

  logic             in_legal;
  logic             in_misal;
  logic [3:0]       in_be;
  logic [31:0]      in_wdata;
  logic [31:0]      ld_shift;
  logic [31:0]      ld_data;

  // Decode of the request presented this cycle, used only at acceptance.
  always_comb begin
    in_legal = 1'b0;
    in_misal = 1'b0;
    in_be    = 4'b1111;
    in_wdata = req_wdata;
    if (req_we)
      in_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else
      in_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                 (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    case (req_funct3[1:0])
      2'b00: begin
        in_be    = 4'b0001 << req_addr[1:0];
        in_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        in_misal = req_addr[0];
        in_be    = 4'b0011 << req_addr[1:0];
        in_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        in_misal = (req_addr[1:0] != 2'b00);
        in_be    = 4'b1111;
        in_wdata = req_wdata;
      end
    endcase
  end

  // Load lane select and extension from the latched size and byte offset.
  always_comb begin
    ld_shift = mem_rdata >> {r_off, 3'b000};
    case (r_f3)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      err_wait  <= 1'b0;
      r_we      <= 1'b0;
      r_f3      <= 3'd0;
      r_off     <= 2'd0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (req_valid && req_ready) begin
            r_we      <= req_we;
            r_f3      <= req_funct3;
            r_off     <= req_addr[1:0];
            cnt       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_rdata <= 32'd0;
            if (!in_legal || in_misal) begin
              state    <= DONE;
              err_wait <= 1'b1;
              rsp_err  <= 1'b1;
            end else begin
              state     <= REQ;
              rsp_err   <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= in_be;
              mem_wdata <= in_wdata;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        REQ: begin
          if (mem_gnt && (r_we || mem_rvalid)) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= r_we ? 32'd0 : ld_data;
          end else if (cnt == CNT_LAST) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'd0;
          end else begin
            cnt <= cnt + 1'b1;
            if (mem_gnt) begin
              state   <= WAIT_R;
              mem_req <= 1'b0;
            end
          end
        end

        WAIT_R: begin
          if (mem_rvalid) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= ld_data;
          end else if (cnt == CNT_LAST) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          // Errors detected at acceptance hold here one cycle so the
          // response lands two cycles after acceptance.
          if (err_wait) begin
            err_wait  <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: expected responses are queued at acceptance
// and compared when rsp_valid pulses.
module tb_lsu_bus_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  lsu_bus_ctrl #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_rsp  = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, want, cyc);
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
      n_rsp++;
    end
  end

  task automatic drive_idle();
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
  endtask

  // gnt/rv give the cycle (relative to acceptance) of each bus pulse; 0 = never.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gnt, input int rv,
                         input logic [31:0] rdata_in, input bit exp_req,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat);
    int  k;
    int  c0;
    int  n0;
    int  lim;
    bit  got;
    exp_t e;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    c0 = cyc;
    n0 = n_rsp;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.cyc   = c0 + lat;
    sb.push_back(e);
    lim = (gnt > 0) ? gnt : 16;
    got = 1'b0;
    for (k = 1; k <= 40 && !got; k++) begin
      @(negedge clk); #1;
      if (n_rsp != n0) got = 1'b1;
      chk("mem_req", {31'd0, mem_req}, {31'd0, (exp_req && k <= lim)});
      if (k == 1) begin
        chk("busy", {31'd0, busy}, 32'd1);
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
        if (exp_req) begin
          chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
          chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
          chk("mem_we", {31'd0, mem_we}, {31'd0, we});
          if (we) chk("mem_wdata", mem_wdata, exp_wd);
        end
      end
      // Garbage on req_* while busy must be ignored.
      req_valid  = (k <= 2);
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      mem_gnt    = (k == gnt);
      mem_rvalid = (k == rv);
      mem_rdata  = rdata_in;
    end
    if (!got) chk("rsp_wait_expired", 32'd0, 32'd1);
    drive_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    //      we    f3      addr          wdata         gnt rv rdata_in      req be       wd            rdata         err  lat
    run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0,        1, 3, 32'hDEAD_BEEF, 1, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0, 4);
    run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0,        1, 1, 32'h80FF_0000, 1, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0, 2);
    run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0,        2, 2, 32'h80FF_0000, 1, 4'b1000, 32'h0,        32'h0000_0080, 1'b0, 3);
    run_txn(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 0, 32'h0,       1, 4'b1100, 32'hABCD_ABCD, 32'h0,         1'b0, 4);
    run_txn(1'b0, 3'b010, 32'h0000_0101, 32'h0,        0, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,         1'b1, 2);
    run_txn(1'b0, 3'b011, 32'h0000_0100, 32'h0,        0, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,         1'b1, 2);
    run_txn(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00EF, 1, 0, 32'h0,       1, 4'b0010, 32'hEFEF_EFEF, 32'h0,         1'b0, 2);
    run_txn(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 2, 0, 32'h0,       1, 4'b1111, 32'hCAFE_F00D, 32'h0,         1'b0, 3);
    run_txn(1'b0, 3'b001, 32'h0000_0102, 32'h0,        1, 2, 32'h8001_1234, 1, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0, 3);
    run_txn(1'b0, 3'b101, 32'h0000_0100, 32'h0,        1, 1, 32'h0000_F00D, 1, 4'b0011, 32'h0,        32'h0000_F00D, 1'b0, 2);
    run_txn(1'b1, 3'b100, 32'h0000_0100, 32'h5555_5555, 0, 0, 32'h0,       0, 4'b0000, 32'h0,        32'h0,         1'b1, 2);
    run_txn(1'b1, 3'b001, 32'h0000_0203, 32'h5555_5555, 0, 0, 32'h0,       0, 4'b0000, 32'h0,        32'h0,         1'b1, 2);
    run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0,        1, 0, 32'h1111_1111, 1, 4'b1111, 32'h0,        32'h0,         1'b1, 17);
    run_txn(1'b0, 3'b010, 32'h0000_0104, 32'h0,        0, 0, 32'h2222_2222, 1, 4'b1111, 32'h0,        32'h0,         1'b1, 17);
    run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0,        1, 1, 32'h0BAD_CAFE, 1, 4'b1111, 32'h0,        32'h0BAD_CAFE, 1'b0, 2);

    // Reset while waiting for read data.
    @(negedge clk); #1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0400;
    @(negedge clk); #1;
    drive_idle();
    mem_gnt = 1'b1;
    @(negedge clk); #1;
    mem_gnt = 1'b0;
    chk("waitr_busy", {31'd0, busy}, 32'd1);
    chk("waitr_mem_req", {31'd0, mem_req}, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    @(negedge clk); #1;
    chk("midrst_ready_hold", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk); #1;
    mem_rvalid = 1'b0;
    chk("postrst_ready", {31'd0, req_ready}, 32'd1);
    chk("postrst_busy", {31'd0, busy}, 32'd0);

    run_txn(1'b1, 3'b010, 32'h0000_0500, 32'h0123_4567, 1, 0, 32'h0, 1, 4'b1111, 32'h0123_4567, 32'h0, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Load/store unit directly downstream of the core's ALU/register-file datapath.
- Takes one load or store request per transaction (effective address, store data, funct3) and runs it on a request/grant/response data bus.
- Generates byte enables and lane-aligned write data; sign- or zero-extends load data.
- Reports misalignment, illegal size and bus timeout; the core stalls on busy.

Parameters:
TIMEOUT_CYC, 16, cycles spent in REQ or WAIT_R (combined) before the transaction aborts with err.
CNT_W, 5, timeout counter width; must hold TIMEOUT_CYC.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low
req_valid  input  1  core presents a transaction
req_ready  output  1  LSU can accept (IDLE only)
req_we  input  1  1=store, 0=load
req_funct3  input  3  RV32I size/sign field
req_addr  input  32  effective byte address
req_wdata  input  32  store data (rs2)
busy  output  1  transaction in flight; core stall
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  32  extended load data, valid with rsp_valid
rsp_err  output  1  misaligned/illegal/timeout, valid with rsp_valid
mem_req  output  1  bus request
mem_we  output  1  bus write
mem_addr  output  32  word address (bits [1:0] forced 00)
mem_be  output  4  byte enables
mem_wdata  output  32  lane-aligned write data
mem_gnt  input  1  bus accepted request
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read word

Behaviour:
- States: IDLE, REQ, WAIT_R, DONE. rst=0 at a clock edge: state→IDLE, counter and all registered outputs →0, rsp_rdata=0.
- While rst=0, req_ready=0. After rst=1, req_ready=1 in IDLE only. busy=1 in REQ/WAIT_R/DONE.
- Accept when IDLE & req_valid & req_ready: latch we/funct3/addr/wdata. Later changes on req_* are ignored until the next IDLE.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other value is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00. Byte access is never misaligned.
- Illegal or misaligned request: next state DONE, no mem_req, rsp_err=1, rsp_rdata=0. rsp_valid asserts 2 cycles after acceptance.
- REQ: mem_req=1, with mem_we/mem_addr/mem_be/mem_wdata held stable until mem_gnt.
  - Store + gnt → DONE.
  - Load + gnt → WAIT_R.
  - Load + gnt + rvalid in the same cycle → DONE, data captured.
  - mem_rvalid in REQ without gnt is ignored.
- mem_req drops the cycle after gnt.
- WAIT_R: mem_req=0. On mem_rvalid, capture mem_rdata, extend, → DONE.
- Byte enables:
  - SB/LB/LBU: be = 0001<<addr[1:0]; store byte replicated on all 4 lanes.
  - SH/LH/LHU: be = 0011<<addr[1:0]; store halfword replicated on both halves.
  - Word: be = 1111.
- Load extract: select the byte/halfword at addr offset. LB/LH sign-extend from the top bit; LBU/LHU zero-extend.
- Timeout: counter clears on accept and increments each cycle in REQ/WAIT_R. When it reaches TIMEOUT_CYC−1 without completing: → DONE, rsp_err=1, rsp_rdata=0, mem_req=0.
- DONE: rsp_valid=1 for exactly 1 cycle, then → IDLE. req_valid during DONE is not accepted.
- Best-case latency (zero-wait bus):
  - Store: accept@0, gnt@1, rsp_valid@2.
  - Load with gnt+rvalid in the same cycle: rsp_valid@2.
- Reset mid-transaction: the transaction is abandoned, no rsp_valid, mem_req=0 after the edge.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, gnt@1, rvalid@3 → mem_addr=0x100, be=1111; rsp_rdata=0xDEADBEEF, err=0, rsp_valid@4.
- LB addr=0x103, mem_rdata=0x80FF_0000; then LBU same → rsp_rdata=0xFFFFFF80, then 0x00000080.
- SH addr=0x202, wdata=0x1234ABCD, gnt@3 → mem_req held cycles 1–3, mem_addr=0x200, be=1100, mem_wdata=0xABCDABCD, rsp_valid@4.
- LW addr=0x101; then funct3=011 → no mem_req, rsp_err=1, rsp_valid 2 cycles after accept, rdata=0.
- Load with gnt but no rvalid, TIMEOUT_CYC=16 → rsp_err=1 after 16 cycles in REQ/WAIT_R; next request accepted normally.
- rst=0 while in WAIT_R → IDLE next edge, no rsp_valid, req_ready=0 until rst=1, late mem_rvalid ignored.
